exc_sequencer: RTL and testbench

- Central exception/interrupt controller for the 5-stage MIPS pipeline.
- Takes the ExcCode carried down the pipe into stage M, plus the 6 hardware interrupt lines and ERET.
- Holds the CP0 SR/Cause/EPC/PRId registers.
- Sequences the pipeline flush and then redirects fetch to the handler or back to EPC.
- Sits beside stage M; its Flush/Redirect outputs drive every pipeline register and the PC mux.

---
 rtl/exc_sequencer.sv | 157 +++++++++++++++
 tb/tb_exc_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/exc_sequencer.sv
// CP0 exception/interrupt sequencer beside stage M.
// Holds SR/Cause/EPC/PRId, arbitrates interrupt/exception/ERET/mtc0,
// then holds Flush for FLUSH_CYCLES cycles with Redirect on the last one.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | normal operation; events and mtc0 are accepted from stage M
// ST_FLUSH | pipeline being cleared; Redirect fires on the cycle cnt == 0
module exc_sequencer #(
   parameter int          FLUSH_CYCLES = 2,
   parameter logic [31:0] HANDLER      = 32'h0000_4180,
   parameter logic [31:0] PRID         = 32'h4C57_0001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ExcCodeM,
   input  logic [31:0] PCM,
   input  logic        BDM,
   input  logic        ValidM,
   input  logic        EretM,
   input  logic [5:0]  HWInt,
   input  logic        WeCP0,
   input  logic [4:0]  A,
   input  logic [31:0] DIn,
   output logic [31:0] DOut,
   output logic [31:0] EPCOut,
   output logic        Flush,
   output logic        Redirect,
   output logic [31:0] NPC,
   output logic        ExlOut
);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t      state, state_nxt;
   logic [2:0]  cnt;
   logic [31:0] npc_q;

   logic [5:0]  sr_im;
   logic        sr_exl, sr_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] epc;

   logic        int_req, exc_req;
   logic        take_int, take_exc, take_eret, take_mtc0;

   logic [31:0] sr_word, cause_word;

   assign int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl & ValidM;
   assign exc_req = ValidM & (ExcCodeM != 5'd0);

   assign sr_word    = {16'h0, sr_im, 8'h0, sr_exl, sr_ie};
   assign cause_word = {cause_bd, 15'h0, cause_ip, 3'h0, cause_exc, 2'h0};

   assign EPCOut = epc;
   assign NPC    = npc_q;
   assign ExlOut = sr_exl;

   // mfc0 read mux
   always_comb begin
      DOut = 32'h0;
      case (A)
         5'd12:   DOut = sr_word;
         5'd13:   DOut = cause_word;
         5'd14:   DOut = epc;
         5'd15:   DOut = PRID;
         default: DOut = 32'h0;
      endcase
   end

   // Next-state, event arbitration and flush/redirect outputs
   always_comb begin
      state_nxt = state;
      take_int  = 1'b0;
      take_exc  = 1'b0;
      take_eret = 1'b0;
      take_mtc0 = 1'b0;
      Flush     = 1'b0;
      Redirect  = 1'b0;
      case (state)
         ST_RUN: begin
            if (int_req)                 take_int  = 1'b1;
            else if (exc_req)            take_exc  = 1'b1;
            else if (ValidM && EretM)    take_eret = 1'b1;
            else if (ValidM && WeCP0)    take_mtc0 = 1'b1;
            if (take_int || take_exc || take_eret) state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            Flush = 1'b1;
            if (cnt == 3'd0) begin
               Redirect  = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_RUN;
      else       state <= state_nxt;
   end

   // Flush down-counter and redirect target
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= 3'd0;
         npc_q <= 32'h0;
      end else if (take_int || take_exc) begin
         cnt   <= 3'(FLUSH_CYCLES - 1);
         npc_q <= HANDLER;
      end else if (take_eret) begin
         cnt   <= 3'(FLUSH_CYCLES - 1);
         npc_q <= epc;
      end else if (state == ST_FLUSH && cnt != 3'd0) begin
         cnt <= cnt - 3'd1;
      end
   end

   // CP0 registers; IP tracks HWInt every cycle regardless of state
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im     <= 6'h0;
         sr_exl    <= 1'b0;
         sr_ie     <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ip  <= 6'h0;
         cause_exc <= 5'h0;
         epc       <= 32'h0;
      end else begin
         cause_ip <= HWInt;
         if (take_int || take_exc) begin
            cause_exc <= take_int ? 5'd0 : ExcCodeM;
            // a nested exception keeps the original return point
            if (!sr_exl) begin
               epc      <= BDM ? (PCM - 32'd4) : PCM;
               cause_bd <= BDM;
               sr_exl   <= 1'b1;
            end
         end else if (take_eret) begin
            sr_exl <= 1'b0;
         end else if (take_mtc0) begin
            if (A == 5'd12) begin
               sr_im  <= DIn[15:10];
               sr_exl <= DIn[1];
               sr_ie  <= DIn[0];
            end else if (A == 5'd14) begin
               epc <= DIn;
            end
         end
      end
   end

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the CP0 rules.
module tb_exc_sequencer;

   localparam int          FC      = 2;
   localparam logic [31:0] HANDLER = 32'h0000_4180;
   localparam logic [31:0] PRID    = 32'h4C57_0001;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ExcCodeM;
   logic [31:0] PCM;
   logic        BDM, ValidM, EretM, WeCP0;
   logic [5:0]  HWInt;
   logic [4:0]  A;
   logic [31:0] DIn;
   logic [31:0] DOut, EPCOut, NPC;
   logic        Flush, Redirect, ExlOut;

   int errors = 0;
   int checks = 0;

   // model state
   logic [5:0]  m_im, m_ip;
   logic        m_exl, m_ie, m_bd;
   logic [4:0]  m_exc;
   logic [31:0] m_epc, m_npc;
   int          m_busy;   // flush cycles still to come after this edge

   exc_sequencer #(.FLUSH_CYCLES(FC), .HANDLER(HANDLER), .PRID(PRID)) dut (
      .clk(clk), .reset(reset), .ExcCodeM(ExcCodeM), .PCM(PCM), .BDM(BDM),
      .ValidM(ValidM), .EretM(EretM), .HWInt(HWInt), .WeCP0(WeCP0), .A(A),
      .DIn(DIn), .DOut(DOut), .EPCOut(EPCOut), .Flush(Flush),
      .Redirect(Redirect), .NPC(NPC), .ExlOut(ExlOut)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return {16'h0, m_im, 8'h0, m_exl, m_ie};
         5'd13:   return {m_bd, 15'h0, m_ip, 3'h0, m_exc, 2'h0};
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   task automatic model_update();
      logic irq, exq;
      if (reset) begin
         m_im = '0; m_ip = '0; m_exl = 0; m_ie = 0; m_bd = 0;
         m_exc = '0; m_epc = '0; m_npc = '0; m_busy = 0;
         return;
      end
      m_ip = HWInt;
      if (m_busy > 0) begin
         m_busy--;
         return;
      end
      irq = ((HWInt & m_im) != 6'h0) && m_ie && !m_exl && ValidM;
      exq = ValidM && (ExcCodeM != 5'd0);
      if (irq || exq) begin
         if (!m_exl) begin
            m_epc = BDM ? PCM - 32'd4 : PCM;
            m_bd  = BDM;
            m_exl = 1'b1;
         end
         m_exc  = irq ? 5'd0 : ExcCodeM;
         m_npc  = HANDLER;
         m_busy = FC;
      end else if (ValidM && EretM) begin
         m_exl  = 1'b0;
         m_npc  = m_epc;
         m_busy = FC;
      end else if (ValidM && WeCP0) begin
         if (A == 5'd12) begin
            m_im = DIn[15:10]; m_exl = DIn[1]; m_ie = DIn[0];
         end else if (A == 5'd14) begin
            m_epc = DIn;
         end
      end
   endtask

   // Check outputs against the model, then clock once with the current inputs.
   task automatic cycle();
      #1;
      chk("dout",     DOut,            m_read(A));
      chk("epc",      EPCOut,          m_epc);
      chk("exl",      32'(ExlOut),     32'(m_exl));
      chk("flush",    32'(Flush),      32'(m_busy > 0));
      chk("redirect", 32'(Redirect),   32'(m_busy == 1));
      chk("npc",      NPC,             m_npc);
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      reset = 0; ExcCodeM = 0; PCM = 32'h0; BDM = 0; ValidM = 1; EretM = 0;
      WeCP0 = 0; A = 5'd13; DIn = 32'h0;
   endtask

   initial begin
      idle();
      HWInt = 6'h0;
      reset = 1;
      m_busy = 0; m_im = '0; m_ip = '0; m_exl = 0; m_ie = 0; m_bd = 0;
      m_exc = '0; m_epc = '0; m_npc = '0;
      @(posedge clk); model_update(); #1;
      cycle();
      reset = 0;

      // reset state readback
      for (int a = 12; a <= 15; a++) begin
         A = 5'(a);
         cycle();
      end
      A = 5'd15; #1;
      chk("prid_const", DOut, 32'h4C57_0001);
      chk("rst_flush", 32'(Flush), 32'h0);

      // plain exception, code 10
      idle(); ExcCodeM = 5'd10; PCM = 32'h3004;
      cycle();
      idle();
      chk("exc_epc", EPCOut, 32'h3004);
      A = 5'd13; #1;
      chk("exc_cause", DOut, 32'h28);
      chk("exc_flush1", {Flush, Redirect}, 32'h2);
      cycle();
      chk("exc_redir", {Flush, Redirect}, 32'h3);
      chk("exc_npc", NPC, 32'h4180);
      cycle();
      chk("exc_run", {Flush, Redirect}, 32'h0);

      // enable IM[0]/IE, then interrupt beats a same-cycle exception
      idle(); WeCP0 = 1; A = 5'd12; DIn = 32'h0000_0401;
      cycle();
      idle(); HWInt = 6'b000001; PCM = 32'h3010; BDM = 1; ExcCodeM = 5'd4;
      cycle();
      idle(); HWInt = 6'h0;
      chk("int_epc", EPCOut, 32'h300C);
      #1;
      chk("int_cause", DOut, 32'h8000_0400);
      repeat (2) cycle();

      // ERET back to a written EPC; interrupt during FLUSH is ignored
      idle(); WeCP0 = 1; A = 5'd14; DIn = 32'h3020;
      cycle();
      idle(); EretM = 1;
      cycle();
      idle(); HWInt = 6'b000001;
      chk("eret_exl", 32'(ExlOut), 32'h0);
      cycle();
      chk("eret_npc", NPC, 32'h3020);
      chk("eret_redir", 32'(Redirect), 32'h1);
      cycle();
      HWInt = 6'h0;
      cycle();
      chk("eret_noint", 32'(Flush), 32'h0);

      // reset lands in the middle of a flush
      idle(); ExcCodeM = 5'd8; PCM = 32'h5000;
      cycle();
      idle(); reset = 1;
      cycle();
      reset = 0;
      chk("rst_mid_flush", {Flush, Redirect}, 32'h0);
      chk("rst_mid_epc", EPCOut, 32'h0);
      repeat (3) cycle();

      // bubble blocks events; PCM-4 wraps
      idle(); WeCP0 = 1; A = 5'd12; DIn = 32'h0000_0401;
      cycle();
      idle(); ValidM = 0; ExcCodeM = 5'd12; HWInt = 6'b000001; A = 5'd14;
      cycle();
      chk("bubble_flush", 32'(Flush), 32'h0);
      idle(); HWInt = 6'h0; ExcCodeM = 5'd12; PCM = 32'h0; BDM = 1;
      cycle();
      idle();
      chk("wrap_epc", EPCOut, 32'hFFFF_FFFC);
      repeat (3) cycle();

      // random traffic
      for (int i = 0; i < 800; i++) begin
         reset    = ($urandom_range(0, 59) == 0);
         ValidM   = ($urandom_range(0, 4) != 0);
         ExcCodeM = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         EretM    = ($urandom_range(0, 9) == 0);
         WeCP0    = ($urandom_range(0, 3) == 0);
         HWInt    = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'h0;
         PCM      = {$urandom_range(0, 3) == 0 ? 30'h0 : 30'($urandom), 2'b00};
         BDM      = 1'($urandom);
         A        = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
         DIn      = $urandom;
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
